// File: rtl/ibex_rf_wb_pkg.sv
// ----------------------------------------------------------------------------
// ibex_rf_wb_pkg
// Shared types and constants for the register-file write-back front end:
//   - rf_wb_state_e : load-tracking FSM states (IDLE / WAIT)
//   - RF_ADDR_W     : register address width
//   - RF_DATA_W     : data width carried by the write-request struct
//   - rf_wr_req_t   : one register-file write request (addr, data, we)
//   - rf_addr_mask  : drops address bit 4 for RV32E cores
// ----------------------------------------------------------------------------
package ibex_rf_wb_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [0:0] {
    RF_WB_IDLE = 1'b0,
    RF_WB_WAIT = 1'b1
  } rf_wb_state_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
    logic                 we;
  } rf_wr_req_t;

  // RV32E only has 16 registers: bit 4 is neither compared nor written.
  function automatic logic [RF_ADDR_W-1:0] rf_addr_mask(input logic [RF_ADDR_W-1:0] addr,
                                                        input bit                   rv32e);
    logic [RF_ADDR_W-1:0] res;
    res = addr;
    if (rv32e) begin
      res[RF_ADDR_W-1] = 1'b0;
    end else begin
      res = addr;
    end
    return res;
  endfunction

endpackage

// File: rtl/ibex_rf_writeback_if.sv
// ----------------------------------------------------------------------------
// ibex_rf_writeback_if
// Bundles the EX result handshake and the LSU load issue/response signals
// feeding the write-back front end.
//   master : EX/LSU side (drives valid/addr/data, receives ex_ready/ld_busy)
//   slave  : write-back block
// ----------------------------------------------------------------------------
interface ibex_rf_writeback_if
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned DataWidth = RF_DATA_W
);
  // EX result channel
  logic                 ex_valid;
  logic [RF_ADDR_W-1:0] ex_waddr;
  logic [DataWidth-1:0] ex_wdata;
  logic                 ex_ready;
  // Load issue / response channel
  logic                 ld_issue;
  logic [RF_ADDR_W-1:0] ld_waddr;
  logic                 ld_busy;
  logic                 ld_rvalid;
  logic [DataWidth-1:0] ld_rdata;
  logic                 ld_err;

  modport master (
    output ex_valid, ex_waddr, ex_wdata, ld_issue, ld_waddr, ld_rvalid, ld_rdata, ld_err,
    input  ex_ready, ld_busy
  );

  modport slave (
    input  ex_valid, ex_waddr, ex_wdata, ld_issue, ld_waddr, ld_rvalid, ld_rdata, ld_err,
    output ex_ready, ld_busy
  );
endinterface

// File: rtl/ibex_rf_wb_hazard.sv
// ----------------------------------------------------------------------------
// ibex_rf_wb_hazard
// Read-after-write hazard detection for the two ID read ports.
//   raddr_a_i/raddr_b_i : ID read addresses
//   ld_waddr_i/ld_pend_i: outstanding load destination and its valid flag
//   st_waddr_i/st_we_i  : staged register-file write (not yet in the latches)
//   hazard_o            : ID must stall
// Address x0 never hazards since it is hard-wired to zero.
// ----------------------------------------------------------------------------
module ibex_rf_wb_hazard
  import ibex_rf_wb_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic [RF_ADDR_W-1:0] raddr_a_i,
  input  logic [RF_ADDR_W-1:0] raddr_b_i,
  input  logic [RF_ADDR_W-1:0] ld_waddr_i,
  input  logic                 ld_pend_i,
  input  logic [RF_ADDR_W-1:0] st_waddr_i,
  input  logic                 st_we_i,
  output logic                 hazard_o
);
  logic [RF_ADDR_W-1:0] ra_s, rb_s;
  logic                 a_hit_s, b_hit_s;

  assign ra_s = rf_addr_mask(raddr_a_i, RV32E);
  assign rb_s = rf_addr_mask(raddr_b_i, RV32E);

  assign a_hit_s = (ra_s != 5'd0) &
                   ((ld_pend_i & (ra_s == ld_waddr_i)) | (st_we_i & (ra_s == st_waddr_i)));
  assign b_hit_s = (rb_s != 5'd0) &
                   ((ld_pend_i & (rb_s == ld_waddr_i)) | (st_we_i & (rb_s == st_waddr_i)));

  assign hazard_o = a_hit_s | b_hit_s;
endmodule

// File: rtl/ibex_rf_writeback.sv
// ----------------------------------------------------------------------------
// ibex_rf_writeback
// Write-side front end of the latch-based register file. Merges EX results
// and delayed load responses into one registered write port, tracks the single
// outstanding load destination and flags RAW hazards to ID.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   wb_if (slave)        : EX handshake + load issue/response channel
//   raddr_a_i, raddr_b_i : ID read addresses; rd_hazard_o stalls ID
//   rf_waddr_o/rf_wdata_o/rf_we_o : registered register-file write port
//   err_o                : one-cycle load bus error pulse
// Build option: define IBEX_RF_WB_LOAD_ERR_EN to make ld_err suppress the
// write and pulse err_o; otherwise ld_err is ignored and err_o is tied low.
// ----------------------------------------------------------------------------
module ibex_rf_writeback
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned DataWidth = RF_DATA_W,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_rf_writeback_if.slave   wb_if,
  input  logic [RF_ADDR_W-1:0] raddr_a_i,
  input  logic [RF_ADDR_W-1:0] raddr_b_i,
  output logic                 rd_hazard_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 err_o
);
  rf_wb_state_e         state_q, state_d;
  logic [RF_ADDR_W-1:0] ld_waddr_q, ld_waddr_d;
  logic [RF_ADDR_W-1:0] rf_waddr_q;
  logic [DataWidth-1:0] rf_wdata_q;
  logic                 rf_we_q, err_q, err_d;

  logic [RF_ADDR_W-1:0] ex_waddr_s, ld_waddr_s;
  logic                 ld_busy_s, ld_resp_s, issue_ok_s, waw_s, ex_ready_s, ex_fire_s;
  logic                 ld_err_s;
  rf_wr_req_t           wr_req_s;

  assign ex_waddr_s = rf_addr_mask(wb_if.ex_waddr, RV32E);
  assign ld_waddr_s = rf_addr_mask(wb_if.ld_waddr, RV32E);

`ifdef IBEX_RF_WB_LOAD_ERR_EN
  assign ld_err_s = wb_if.ld_err;
`else
  assign ld_err_s = 1'b0;
`endif

  // A response frees the tracker in the same cycle, so a back-to-back issue is taken.
  assign ld_busy_s  = (state_q == RF_WB_WAIT) & ~wb_if.ld_rvalid;
  assign ld_resp_s  = (state_q == RF_WB_WAIT) & wb_if.ld_rvalid;
  assign issue_ok_s = wb_if.ld_issue & ~ld_busy_s;
  // EX must not overtake an older load to the same register.
  assign waw_s      = (state_q == RF_WB_WAIT) & (ex_waddr_s == ld_waddr_q);
  assign ex_ready_s = ~wb_if.ld_rvalid & ~waw_s;
  assign ex_fire_s  = wb_if.ex_valid & ex_ready_s;

  // Load-tracking FSM next state and destination capture.
  always_comb begin
    state_d    = state_q;
    ld_waddr_d = ld_waddr_q;
    case (state_q)
      RF_WB_IDLE: begin
        if (wb_if.ld_issue) state_d = RF_WB_WAIT;
        else                state_d = RF_WB_IDLE;
      end
      RF_WB_WAIT: begin
        if (wb_if.ld_rvalid && !wb_if.ld_issue) state_d = RF_WB_IDLE;
        else                                    state_d = RF_WB_WAIT;
      end
      default: state_d = RF_WB_IDLE;
    endcase
    if (issue_ok_s) ld_waddr_d = ld_waddr_s;
    else            ld_waddr_d = ld_waddr_q;
  end

  // Write arbitration: the load response cannot stall, so it always wins.
  always_comb begin
    wr_req_s = '0;
    err_d    = ld_resp_s & ld_err_s;
    if (ld_resp_s) begin
      wr_req_s.addr = ld_waddr_q;
      wr_req_s.data = RF_DATA_W'(wb_if.ld_rdata);
      wr_req_s.we   = ~ld_err_s & (ld_waddr_q != 5'd0);
    end else if (ex_fire_s) begin
      wr_req_s.addr = ex_waddr_s;
      wr_req_s.data = RF_DATA_W'(wb_if.ex_wdata);
      wr_req_s.we   = (ex_waddr_s != 5'd0);
    end else begin
      wr_req_s = '0;
    end
  end

  // State, load destination and registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RF_WB_IDLE;
      ld_waddr_q <= 5'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_waddr_q <= ld_waddr_d;
      rf_we_q    <= wr_req_s.we;
      err_q      <= err_d;
      if (wr_req_s.we) begin
        rf_waddr_q <= wr_req_s.addr;
        rf_wdata_q <= DataWidth'(wr_req_s.data);
      end
    end
  end

  ibex_rf_wb_hazard #(
    .RV32E(RV32E)
  ) u_hazard (
    .raddr_a_i (raddr_a_i),
    .raddr_b_i (raddr_b_i),
    .ld_waddr_i(ld_waddr_q),
    .ld_pend_i (state_q == RF_WB_WAIT),
    .st_waddr_i(rf_waddr_q),
    .st_we_i   (rf_we_q),
    .hazard_o  (rd_hazard_o)
  );

  assign wb_if.ex_ready = ex_ready_s;
  assign wb_if.ld_busy  = ld_busy_s;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign rf_we_o        = rf_we_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_ibex_rf_writeback.sv
// ----------------------------------------------------------------------------
// tb_ibex_rf_writeback
// Scenario tasks drive the write-back front end; expected register-file
// writes are queued when stimulus is accepted and checked in order by a
// monitor whenever rf_we_o is seen high.
// ----------------------------------------------------------------------------
module tb_ibex_rf_writeback;
  import ibex_rf_wb_pkg::*;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst_ni;
  logic [4:0]  raddr_a, raddr_b;
  logic        rd_hazard;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic        err;
  logic        mon_en;
  int          n_checks;
  int          n_fail;
  exp_t        sb_q[$];
  exp_t        mon_e;

  ibex_rf_writeback_if #(.DataWidth(32)) wb_if ();

  ibex_rf_writeback #(.DataWidth(32), .RV32E(1'b0)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .wb_if      (wb_if),
    .raddr_a_i  (raddr_a),
    .raddr_b_i  (raddr_b),
    .rd_hazard_o(rd_hazard),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata),
    .rf_we_o    (rf_we),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the oldest expected one.
  always @(negedge clk) begin
    if (mon_en && rf_we === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
          n_fail++;
          $display("FAIL write_data: got x%0d=%h, required x%0d=%h", rf_waddr, rf_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wb_if.ex_valid  = 1'b0;
    wb_if.ex_waddr  = 5'd0;
    wb_if.ex_wdata  = 32'd0;
    wb_if.ld_issue  = 1'b0;
    wb_if.ld_waddr  = 5'd0;
    wb_if.ld_rvalid = 1'b0;
    wb_if.ld_rdata  = 32'd0;
    wb_if.ld_err    = 1'b0;
    raddr_a         = 5'd0;
    raddr_b         = 5'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    #12;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, err} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got we=%b a=%0d d=%h err=%b, required all 0", rf_we, rf_waddr, rf_wdata, err);
    end
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wb_if.ex_ready, wb_if.ld_busy, rd_hazard} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_comb: got ready/busy/hazard=%b, required 100", {wb_if.ex_ready, wb_if.ld_busy, rd_hazard});
    end
    next_cycle();
    mon_en = 1'b1;
  endtask

  task automatic test_ex_write();
    wb_if.ex_valid = 1'b1;
    wb_if.ex_waddr = 5'd5;
    wb_if.ex_wdata = 32'hDEADBEEF;
    sb_q.push_back('{5'd5, 32'hDEADBEEF});
    @(negedge clk);
    n_checks++;
    if (wb_if.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ex_ready_idle: got %b, required 1", wb_if.ex_ready);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_we_one_cycle: got %b, required 0", rf_we);
    end
    next_cycle();
  endtask

  task automatic test_load_hazard();
    wb_if.ld_issue = 1'b1;
    wb_if.ld_waddr = 5'd7;
    raddr_a        = 5'd7;
    next_cycle();
    wb_if.ld_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_hazard, wb_if.ld_busy} !== 2'b11) begin
        n_fail++;
        $display("FAIL ld_wait_hazard: got hazard/busy=%b, required 11", {rd_hazard, wb_if.ld_busy});
      end
      next_cycle();
    end
    wb_if.ld_rvalid = 1'b1;
    wb_if.ld_rdata  = 32'h1234;
    sb_q.push_back('{5'd7, 32'h1234});
    @(negedge clk);
    n_checks++;
    if ({rd_hazard, wb_if.ld_busy, wb_if.ex_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL ld_resp_cycle: got hazard/busy/ready=%b, required 100", {rd_hazard, wb_if.ld_busy, wb_if.ex_ready});
    end
    next_cycle();
    wb_if.ld_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL staged_hazard: got %b, required 1", rd_hazard);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rd_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hazard_clear: got %b, required 0", rd_hazard);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_collision();
    wb_if.ld_issue = 1'b1;
    wb_if.ld_waddr = 5'd2;
    next_cycle();
    wb_if.ld_issue  = 1'b0;
    next_cycle();
    wb_if.ld_rvalid = 1'b1;
    wb_if.ld_rdata  = 32'hAAAA_0002;
    wb_if.ex_valid  = 1'b1;
    wb_if.ex_waddr  = 5'd3;
    wb_if.ex_wdata  = 32'h3333_3333;
    sb_q.push_back('{5'd2, 32'hAAAA_0002});
    @(negedge clk);
    n_checks++;
    if (wb_if.ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_ready: got %b, required 0", wb_if.ex_ready);
    end
    next_cycle();
    wb_if.ld_rvalid = 1'b0;
    sb_q.push_back('{5'd3, 32'h3333_3333});
    @(negedge clk);
    n_checks++;
    if (wb_if.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_retry: got %b, required 1", wb_if.ex_ready);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_waw_hold();
    wb_if.ld_issue = 1'b1;
    wb_if.ld_waddr = 5'd9;
    next_cycle();
    wb_if.ld_issue = 1'b0;
    wb_if.ex_valid = 1'b1;
    wb_if.ex_waddr = 5'd9;
    wb_if.ex_wdata = 32'h9999_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (wb_if.ex_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL waw_ready: got %b, required 0", wb_if.ex_ready);
      end
      next_cycle();
    end
    wb_if.ld_rvalid = 1'b1;
    wb_if.ld_rdata  = 32'h0000_009A;
    sb_q.push_back('{5'd9, 32'h0000_009A});
    next_cycle();
    wb_if.ld_rvalid = 1'b0;
    sb_q.push_back('{5'd9, 32'h9999_0000});
    @(negedge clk);
    n_checks++;
    if (wb_if.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_release: got %b, required 1", wb_if.ex_ready);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_x0_and_back_to_back();
    wb_if.ex_valid = 1'b1;
    wb_if.ex_waddr = 5'd0;
    wb_if.ex_wdata = 32'h5555_5555;
    @(negedge clk);
    n_checks++;
    if (wb_if.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: got %b, required 1", wb_if.ex_ready);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_dropped: got %b, required 0", rf_we);
    end
    next_cycle();
    wb_if.ld_issue = 1'b1;
    wb_if.ld_waddr = 5'd6;
    next_cycle();
    wb_if.ld_issue = 1'b0;
    next_cycle();
    wb_if.ld_rvalid = 1'b1;
    wb_if.ld_rdata  = 32'h0000_0066;
    wb_if.ld_issue  = 1'b1;
    wb_if.ld_waddr  = 5'd4;
    sb_q.push_back('{5'd6, 32'h0000_0066});
    @(negedge clk);
    n_checks++;
    if (wb_if.ld_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy_resp: got %b, required 0", wb_if.ld_busy);
    end
    next_cycle();
    wb_if.ld_rvalid = 1'b0;
    wb_if.ld_issue  = 1'b1;
    wb_if.ld_waddr  = 5'd8;
    raddr_b         = 5'd4;
    @(negedge clk);
    n_checks++;
    if ({wb_if.ld_busy, rd_hazard} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_track: got busy/hazard=%b, required 11", {wb_if.ld_busy, rd_hazard});
    end
    next_cycle();
    wb_if.ld_issue  = 1'b0;
    raddr_b         = 5'd8;
    @(negedge clk);
    n_checks++;
    if (rd_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_while_busy: got hazard %b, required 0", rd_hazard);
    end
    next_cycle();
    wb_if.ld_rvalid = 1'b1;
    wb_if.ld_rdata  = 32'h0000_0044;
    sb_q.push_back('{5'd4, 32'h0000_0044});
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (wb_if.ld_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b, required 0", wb_if.ld_busy);
    end
    next_cycle();
  endtask

  task automatic test_spurious_rvalid();
    wb_if.ld_rvalid = 1'b1;
    wb_if.ld_rdata  = 32'hFFFF_0000;
    wb_if.ld_err    = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wb_if.ex_ready, wb_if.ld_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL spurious_comb: got ready/busy=%b, required 00", {wb_if.ex_ready, wb_if.ld_busy});
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if ({rf_we, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL spurious_ignored: got we/err=%b, required 00", {rf_we, err});
    end
    next_cycle();
  endtask

  task automatic test_load_err();
    wb_if.ld_issue = 1'b1;
    wb_if.ld_waddr = 5'd10;
    raddr_a        = 5'd10;
    next_cycle();
    wb_if.ld_issue  = 1'b0;
    next_cycle();
    wb_if.ld_rvalid = 1'b1;
    wb_if.ld_err    = 1'b1;
    wb_if.ld_rdata  = 32'h0000_0BAD;
`ifndef IBEX_RF_WB_LOAD_ERR_EN
    sb_q.push_back('{5'd10, 32'h0000_0BAD});
`endif
    next_cycle();
    wb_if.ld_rvalid = 1'b0;
    wb_if.ld_err    = 1'b0;
    raddr_a         = 5'd0;
    @(negedge clk);
    n_checks++;
`ifdef IBEX_RF_WB_LOAD_ERR_EN
    if ({err, rf_we, wb_if.ld_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_err_pulse: got err/we/busy=%b, required 100", {err, rf_we, wb_if.ld_busy});
    end
`else
    if ({err, wb_if.ld_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_err_ignored: got err/busy=%b, required 00", {err, wb_if.ld_busy});
    end
`endif
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_one_cycle: got %b, required 0", err);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    wb_if.ld_issue = 1'b1;
    wb_if.ld_waddr = 5'd11;
    raddr_a        = 5'd11;
    next_cycle();
    wb_if.ld_issue = 1'b0;
    wb_if.ex_valid = 1'b1;
    wb_if.ex_waddr = 5'd12;
    wb_if.ex_wdata = 32'hCCCC_CCCC;
    next_cycle();
    wb_if.ex_valid = 1'b0;
    rst_ni         = 1'b0;
    #1;
    n_checks++;
    if ({rf_we, wb_if.ld_busy, rd_hazard} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: got we/busy/hazard=%b, required 000", {rf_we, wb_if.ld_busy, rd_hazard});
    end
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rf_we, wb_if.ld_busy, wb_if.ex_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL after_reset: got we/busy/ready=%b, required 001", {rf_we, wb_if.ld_busy, wb_if.ex_ready});
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clk      = 1'b0;
    rst_ni   = 1'b0;
    mon_en   = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    test_reset();
    test_ex_write();
    test_load_hazard();
    test_collision();
    test_waw_hold();
    test_x0_and_back_to_back();
    test_spurious_rvalid();
    test_load_err();
    test_reset_mid();
    next_cycle();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d pending, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
